// File: rtl/mips32_pipe_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips32_pipe_fwd                                                 |
// | Purpose  : 5-stage in-order core (IF/ID/EX/MEM/WB) with optional EX-stage  |
// |            forwarding, load-use interlock, taken-branch flush, load port,  |
// |            debug register read and retired-instruction counter.            |
// | Ports    : clk, rst (sync, active-high)                                    |
// |            load_we/load_sel/load_addr/load_data : memory preload port,     |
// |              honoured only while rst=1 or halted=1 (sel 0=imem, 1=dmem)    |
// |            dbg_raddr/dbg_rdata : combinational register read, R0 = 0       |
// |            pc : fetch PC;  halted : sticky after HLT retires               |
// |            retired_cnt : non-bubble instructions written back              |
// | Config   : MIPS32_PIPE_FORWARD_EN defined   -> full forwarding            |
// |            MIPS32_PIPE_FORWARD_EN undefined -> ID interlocks on RAW        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mips32_pipe_fwd #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 load_we,
  input  logic                                 load_sel,
  input  logic [15:0]                          load_addr,
  input  logic [((XLEN > 32) ? XLEN : 32)-1:0] load_data,
  input  logic [4:0]                           dbg_raddr,
  output logic [XLEN-1:0]                      dbg_rdata,
  output logic [$clog2(IMEM_DEPTH)-1:0]        pc,
  output logic                                 halted,
  output logic [31:0]                          retired_cnt
);
  localparam int PW  = $clog2(IMEM_DEPTH);
  localparam int RAW = $clog2(NREG);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] c_op_add = 6'd0,  c_op_sub  = 6'd1,  c_op_and   = 6'd2;
  localparam logic [5:0] c_op_or  = 6'd3,  c_op_slt  = 6'd4,  c_op_mul   = 6'd5;
  localparam logic [5:0] c_op_lw  = 6'd8,  c_op_sw   = 6'd9,  c_op_addi  = 6'd10;
  localparam logic [5:0] c_op_subi = 6'd11, c_op_slti = 6'd12, c_op_bneqz = 6'd13;
  localparam logic [5:0] c_op_beqz = 6'd14;

  logic [31:0]     r_imem [IMEM_DEPTH];
  logic [XLEN-1:0] r_dmem [DMEM_DEPTH];
  logic [XLEN-1:0] r_rf   [NREG];

  logic [PW-1:0] r_pc;
  logic          r_halted, r_fstop;
  logic [31:0]   r_cnt;
  // IF/ID
  logic          r_fd_v;
  logic [31:0]   r_fd_ir;
  logic [PW-1:0] r_fd_npc;
  // ID/EX
  logic            r_de_v, r_de_wr, r_de_hlt;
  logic [5:0]      r_de_op;
  logic [PW-1:0]   r_de_npc;
  logic [XLEN-1:0] r_de_a, r_de_b, r_de_imm;
  logic [RAW-1:0]  r_de_rs, r_de_rt, r_de_dest;
  // EX/MEM
  logic            r_em_v, r_em_wr, r_em_ld, r_em_st, r_em_hlt;
  logic [RAW-1:0]  r_em_dest;
  logic [XLEN-1:0] r_em_alu, r_em_b;
  // MEM/WB
  logic            r_mw_v, r_mw_wr, r_mw_hlt;
  logic [RAW-1:0]  r_mw_dest;
  logic [XLEN-1:0] r_mw_res;

  logic [5:0]      w_id_op;
  logic [RAW-1:0]  w_id_rs, w_id_rt, w_id_rd, w_id_dest, w_dbg_idx;
  logic            w_id_rr, w_id_iw, w_id_sw, w_id_br, w_id_hlt, w_id_wr, w_id_use_rt;
  logic [XLEN-1:0] w_id_a, w_id_b, w_id_imm, w_ex_a, w_ex_b, w_alu, w_mem_res;
  logic            w_wb_we, w_lu, w_stall, w_freeze, w_taken;
  logic [PW-1:0]   w_target;
  logic            w_unused;

  assign pc          = r_pc;
  assign halted      = r_halted;
  assign retired_cnt = r_cnt;
  assign w_unused    = ^{load_addr, load_data, dbg_raddr, r_fd_ir};

  assign w_dbg_idx = dbg_raddr[RAW-1:0];
  assign dbg_rdata = (w_dbg_idx == '0) ? '0 : r_rf[w_dbg_idx];

  // ---------------- ID: decode and write-first register read ----------------
  assign w_id_op  = r_fd_ir[31:26];
  assign w_id_rs  = r_fd_ir[21 +: RAW];
  assign w_id_rt  = r_fd_ir[16 +: RAW];
  assign w_id_rd  = r_fd_ir[11 +: RAW];
  assign w_id_imm = XLEN'($signed(r_fd_ir[15:0]));

  always_comb begin
    w_id_rr     = (w_id_op <= c_op_mul);
    w_id_iw     = (w_id_op == c_op_lw) || (w_id_op == c_op_addi) ||
                  (w_id_op == c_op_subi) || (w_id_op == c_op_slti);
    w_id_sw     = (w_id_op == c_op_sw);
    w_id_br     = (w_id_op == c_op_beqz) || (w_id_op == c_op_bneqz);
    w_id_hlt    = !(w_id_rr || w_id_iw || w_id_sw || w_id_br);
    w_id_wr     = w_id_rr || w_id_iw;
    w_id_use_rt = w_id_rr || w_id_sw;
    w_id_dest   = w_id_rr ? w_id_rd : w_id_rt;
  end

  assign w_wb_we = r_mw_v && r_mw_wr && (r_mw_dest != '0);
  assign w_id_a  = (w_id_rs == '0) ? '0 :
                   (w_wb_we && r_mw_dest == w_id_rs) ? r_mw_res : r_rf[w_id_rs];
  assign w_id_b  = (w_id_rt == '0) ? '0 :
                   (w_wb_we && r_mw_dest == w_id_rt) ? r_mw_res : r_rf[w_id_rt];

  // ---------------- Hazard detection ----------------
  assign w_lu = r_fd_v && r_de_v && (r_de_op == c_op_lw) &&
                ((r_de_dest == w_id_rs) || (r_de_dest == w_id_rt));
`ifdef MIPS32_PIPE_FORWARD_EN
  assign w_stall = w_lu;
`else
  // Without bypass paths, wait until the producer reaches MEM/WB, where the
  // write-first register file hands the value to ID directly.
  function automatic logic f_pending(input logic [RAW-1:0] idx);
    return (idx != '0) &&
           ((r_de_v && r_de_wr && r_de_dest == idx) ||
            (r_em_v && r_em_wr && r_em_dest == idx));
  endfunction
  assign w_stall = w_lu || (r_fd_v && ((!w_id_hlt && f_pending(w_id_rs)) ||
                                       (w_id_use_rt && f_pending(w_id_rt))));
`endif
  // Fetch stays frozen from the moment HLT is seen in ID until a flush or reset.
  assign w_freeze = r_fstop || (r_fd_v && w_id_hlt);

  // ---------------- EX: operand select, ALU, branch ----------------
  always_comb begin
    w_ex_a = r_de_a;
    w_ex_b = r_de_b;
`ifdef MIPS32_PIPE_FORWARD_EN
    // MEM/WB first, then EX/MEM overrides so the youngest producer wins.
    if (r_mw_v && r_mw_wr && r_mw_dest != '0 && r_mw_dest == r_de_rs) w_ex_a = r_mw_res;
    if (r_mw_v && r_mw_wr && r_mw_dest != '0 && r_mw_dest == r_de_rt) w_ex_b = r_mw_res;
    if (r_em_v && r_em_wr && r_em_dest != '0 && r_em_dest == r_de_rs) w_ex_a = r_em_alu;
    if (r_em_v && r_em_wr && r_em_dest != '0 && r_em_dest == r_de_rt) w_ex_b = r_em_alu;
`endif
  end

  always_comb begin
    w_alu = '0;
    case (r_de_op)
      c_op_add:                    w_alu = w_ex_a + w_ex_b;
      c_op_sub:                    w_alu = w_ex_a - w_ex_b;
      c_op_and:                    w_alu = w_ex_a & w_ex_b;
      c_op_or:                     w_alu = w_ex_a | w_ex_b;
      c_op_slt:                    w_alu = {{(XLEN-1){1'b0}}, (w_ex_a < w_ex_b)};
      c_op_mul:                    w_alu = w_ex_a * w_ex_b;
      c_op_addi, c_op_lw, c_op_sw: w_alu = w_ex_a + r_de_imm;
      c_op_subi:                   w_alu = w_ex_a - r_de_imm;
      c_op_slti:                   w_alu = {{(XLEN-1){1'b0}}, (w_ex_a < r_de_imm)};
      default:                     w_alu = '0;
    endcase
  end

  assign w_taken  = r_de_v && (((r_de_op == c_op_beqz)  && (w_ex_a == '0)) ||
                               ((r_de_op == c_op_bneqz) && (w_ex_a != '0)));
  assign w_target = r_de_npc + r_de_imm[PW-1:0];

  // ---------------- MEM ----------------
  assign w_mem_res = r_em_ld ? r_dmem[r_em_alu[DAW-1:0]] : r_em_alu;

  // ---------------- State update ----------------
  always_ff @(posedge clk) begin
    // Memories are never cleared; the load port and stores are mutually exclusive.
    if (rst || r_halted) begin
      if (load_we) begin
        if (load_sel) r_dmem[load_addr[DAW-1:0]] <= load_data[XLEN-1:0];
        else          r_imem[load_addr[PW-1:0]]  <= load_data[31:0];
      end
    end else if (r_em_v && r_em_st) begin
      r_dmem[r_em_alu[DAW-1:0]] <= r_em_b;
    end

    if (rst) begin
      r_pc     <= '0;
      r_fd_v   <= 1'b0;
      r_de_v   <= 1'b0;
      r_em_v   <= 1'b0;
      r_mw_v   <= 1'b0;
      r_halted <= 1'b0;
      r_fstop  <= 1'b0;
      r_cnt    <= '0;
    end else if (!r_halted) begin
      if (w_wb_we) r_rf[r_mw_dest] <= r_mw_res;
      if (r_mw_v) begin
        r_cnt <= r_cnt + 32'd1;
        if (r_mw_hlt) r_halted <= 1'b1;
      end
      r_mw_v    <= r_em_v;
      r_mw_wr   <= r_em_wr;
      r_mw_hlt  <= r_em_hlt;
      r_mw_dest <= r_em_dest;
      r_mw_res  <= w_mem_res;
      r_em_v    <= r_de_v;
      r_em_wr   <= r_de_wr;
      r_em_ld   <= (r_de_op == c_op_lw);
      r_em_st   <= (r_de_op == c_op_sw);
      r_em_hlt  <= r_de_hlt;
      r_em_dest <= r_de_dest;
      r_em_alu  <= w_alu;
      r_em_b    <= w_ex_b;
      if (w_taken) begin
        r_pc    <= w_target;
        r_fd_v  <= 1'b0;
        r_de_v  <= 1'b0;
        r_fstop <= 1'b0;
      end else begin
        r_fstop <= w_freeze;
        if (w_stall) begin
          r_de_v <= 1'b0;
        end else begin
          r_de_v    <= r_fd_v;
          r_de_wr   <= w_id_wr;
          r_de_hlt  <= w_id_hlt;
          r_de_op   <= w_id_op;
          r_de_npc  <= r_fd_npc;
          r_de_a    <= w_id_a;
          r_de_b    <= w_id_b;
          r_de_imm  <= w_id_imm;
          r_de_rs   <= w_id_rs;
          r_de_rt   <= w_id_rt;
          r_de_dest <= w_id_dest;
          if (w_freeze) begin
            r_fd_v <= 1'b0;
          end else begin
            r_fd_v   <= 1'b1;
            r_fd_ir  <= r_imem[r_pc];
            r_fd_npc <= r_pc + PW'(1);
            r_pc     <= r_pc + PW'(1);
          end
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mips32_pipe_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mips32_pipe_fwd                                              |
// | Purpose  : Directed self-checking bench for mips32_pipe_fwd                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mips32_pipe_fwd;
  localparam logic [5:0] OP_ADD = 6'd0, OP_LW = 6'd8, OP_SW = 6'd9, OP_ADDI = 6'd10;
  localparam logic [5:0] OP_SUBI = 6'd11, OP_BNEQZ = 6'd13, OP_BEQZ = 6'd14, OP_HLT = 6'd63;
  localparam logic [31:0] HLT_W   = {OP_HLT, 26'd0};
  localparam logic [31:0] UNDEF_W = 32'h8000_0000;   // opcode 32: undefined, acts as HLT

`ifdef MIPS32_PIPE_FORWARD_EN
  localparam int T1_CYC = 8;
  localparam int T2_CYC = 9;
`else
  localparam int T1_CYC = 10;
  localparam int T2_CYC = 12;
`endif

  logic        clk = 1'b0;
  logic        rst, load_we, load_sel;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [9:0]  pc;
  logic        halted;
  logic [31:0] retired_cnt;

  int ntests = 0;
  int nfail  = 0;
  logic [31:0] prog[$];

  mips32_pipe_fwd dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .pc(pc), .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // All helper tasks start and end on a falling edge.
  task automatic load_word(input logic sel, input int addr, input logic [31:0] data);
    load_sel  = sel;
    load_addr = 16'(addr);
    load_data = data;
    load_we   = 1'b1;
    @(negedge clk);
    load_we   = 1'b0;
  endtask

  task automatic load_prog();
    rst = 1'b1;
    foreach (prog[i]) load_word(1'b0, i, prog[i]);
  endtask

  task automatic wait_halt(input int limit, output int cyc);
    cyc = 0;
    while (!halted && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("halt_reached", halted, 1);
    @(negedge clk);
  endtask

  task automatic rdreg(input int r, output logic [31:0] v);
    dbg_raddr = 5'(r);
    #1;
    v = dbg_rdata;
  endtask

  // Reads two data words through a small LW program and the debug port.
  task automatic read_mem(input int a, input int b, output logic [31:0] va, output logic [31:0] vb);
    int c;
    prog = '{ri(OP_LW, 5, 0, a), ri(OP_LW, 6, 0, b), UNDEF_W};
    load_prog();
    rst = 1'b0;
    wait_halt(100, c);
    rdreg(5, va);
    rdreg(6, vb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] v, v2;
    rst = 1'b1; load_we = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0; dbg_raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired_cnt, 0);
    @(negedge clk);

    // 1: forwarding chain
    prog = '{ri(OP_ADDI, 1, 0, 10), ri(OP_ADDI, 2, 0, 20), rr(OP_ADD, 3, 1, 2), HLT_W};
    load_prog();
    rst = 1'b0;
    wait_halt(200, cyc);
    chk("t1_halt_cycle", cyc, T1_CYC);
    chk("t1_retired", retired_cnt, 4);
    chk("t1_pc_frozen", pc, 4);
    rdreg(3, v); chk("t1_r3", v, 30);
    rdreg(1, v); chk("t1_r1", v, 10);
    rdreg(0, v); chk("t1_r0", v, 0);
    repeat (3) @(negedge clk);
    chk("t1_retired_sticky", retired_cnt, 4);
    chk("t1_halted_sticky", halted, 1);

    // 2: load-use
    prog = '{ri(OP_LW, 1, 0, 100), rr(OP_ADD, 2, 1, 1), ri(OP_SW, 2, 0, 101), HLT_W};
    load_prog();
    load_word(1'b1, 100, 32'd7);
    rst = 1'b0;
    wait_halt(200, cyc);
    chk("t2_halt_cycle", cyc, T2_CYC);
    chk("t2_retired", retired_cnt, 4);
    rdreg(2, v); chk("t2_r2", v, 14);
    read_mem(101, 100, v, v2);
    chk("t2_dmem101", v, 14);
    chk("t2_dmem100", v2, 7);

    // clear R1..R6
    prog = '{rr(OP_ADD, 1, 0, 0), rr(OP_ADD, 2, 0, 0), rr(OP_ADD, 3, 0, 0),
             rr(OP_ADD, 4, 0, 0), rr(OP_ADD, 5, 0, 0), rr(OP_ADD, 6, 0, 0), HLT_W};
    load_prog();
    rst = 1'b0;
    wait_halt(200, cyc);

    // 3: taken-branch flush
    prog = '{ri(OP_ADDI, 1, 0, 0), ri(OP_BEQZ, 0, 1, 2), ri(OP_ADDI, 2, 0, 5),
             ri(OP_ADDI, 3, 0, 6), ri(OP_ADDI, 4, 0, 7), HLT_W};
    load_prog();
    rst = 1'b0;
    wait_halt(200, cyc);
    chk("t3_retired", retired_cnt, 4);
    rdreg(2, v); chk("t3_r2", v, 0);
    rdreg(3, v); chk("t3_r3", v, 0);
    rdreg(4, v); chk("t3_r4", v, 7);

    // 4: counted loop
    prog = '{ri(OP_ADDI, 1, 0, 3), ri(OP_ADDI, 2, 2, 2), ri(OP_SUBI, 1, 1, 1),
             ri(OP_BNEQZ, 0, 1, -3), HLT_W};
    load_prog();
    rst = 1'b0;
    wait_halt(300, cyc);
    chk("t4_retired", retired_cnt, 11);
    rdreg(2, v); chk("t4_r2", v, 6);
    rdreg(1, v); chk("t4_r1", v, 0);

    // 5: reset while SW is in EX
    prog = '{ri(OP_ADDI, 8, 0, 1), ri(OP_ADDI, 8, 0, 1), ri(OP_ADDI, 8, 0, 1),
             ri(OP_ADDI, 8, 0, 1), ri(OP_SW, 0, 0, 150), HLT_W};
    load_prog();
    load_word(1'b1, 150, 32'd5);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t5_retired_before", retired_cnt, 2);
    chk("t5_pc_before", pc, 6);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_pc_after", pc, 0);
    chk("t5_halted_after", halted, 0);
    chk("t5_retired_after", retired_cnt, 0);
    @(negedge clk);
    read_mem(150, 150, v, v2);
    chk("t5_store_dropped", v, 5);

    // 6: load-port guard
    prog = '{ri(OP_ADDI, 1, 0, 20), ri(OP_SUBI, 1, 1, 1), ri(OP_BNEQZ, 0, 1, -2), HLT_W};
    load_prog();
    load_word(1'b1, 200, 32'd11);
    load_word(1'b1, 201, 32'd22);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    load_word(1'b1, 200, 32'd99);
    chk("t6_running_at_pulse", halted, 0);
    wait_halt(600, cyc);
    chk("t6_retired", retired_cnt, 42);
    load_word(1'b1, 201, 32'd55);
    read_mem(200, 201, v, v2);
    chk("t6_running_write_ignored", v, 11);
    chk("t6_halted_write_taken", v2, 55);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
`default_nettype wire
